// File: rtl/shift_register_controller_if.sv
// Command handshake and shift-register control bundle for shift_register_controller.
// master = command source / register side, slave = controller.
interface shift_register_controller_if #(
    parameter int MAX_CNT_W = 3
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [MAX_CNT_W-1:0] cmd_count;
    logic [3:0]           cmd_data;
    logic                 cmd_fill;
    logic                 cmd_rot;
    logic                 stall;
    logic [3:0]           A;
    logic [1:0]           S;
    logic [3:0]           I;
    logic                 MSB_in;
    logic                 LSB_in;
    logic                 serial_out;
    logic                 busy;
    logic                 done;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, cmd_rot, stall, A,
        input  cmd_ready, S, I, MSB_in, LSB_in, serial_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, cmd_rot, stall, A,
        output cmd_ready, S, I, MSB_in, LSB_in, serial_out, busy, done
    );
endinterface

// File: rtl/shift_register_controller.sv
// Sequences a 4-bit universal shift register through load / shift / rotate commands.
// Latency: LOAD 2 cycles, shifts N + stalls + 1 (+1 for LOAD_SHR); IDLE visited between commands.
// Backpressure: cmd_ready only in IDLE; stall freezes the shift sequence (S forced to hold).
module shift_register_controller #(
    parameter int MAX_CNT_W = 3
) (
    input logic                     clk,
    input logic                     rst,
    shift_register_controller_if.slave bus
);
    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           op_q;
    logic [MAX_CNT_W-1:0] cnt_q;
    logic [3:0]           data_q;
    logic                 fill_q;
    logic                 rot_q;
    logic [1:0]           s_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 accept;
    logic                 right_nxt;
    logic                 right_q;
    logic                 shifting;

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    always_comb begin
        state_nxt = state;
        right_nxt = (op_q != OP_SHL);
        case (state)
            ST_IDLE: begin
                right_nxt = (bus.cmd_op != OP_SHL);
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_LOAD_SHR)
                        state_nxt = ST_LOAD;
                    else if (bus.cmd_count != '0)
                        state_nxt = ST_SHIFT;
                    else
                        state_nxt = ST_DONE;
                end
            end
            ST_LOAD: begin
                if (op_q == OP_LOAD || cnt_q == '0)
                    state_nxt = ST_DONE;
                else
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!bus.stall && cnt_q == MAX_CNT_W'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so S/busy/done/ready never see cmd_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            data_q  <= 4'b0000;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
            s_q     <= S_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= (state_nxt == ST_DONE);
            ready_q <= (state_nxt == ST_IDLE);
            case (state_nxt)
                ST_LOAD:  s_q <= S_LOAD;
                ST_SHIFT: s_q <= right_nxt ? S_RIGHT : S_LEFT;
                default:  s_q <= S_HOLD;
            endcase
            if (accept) begin
                op_q   <= bus.cmd_op;
                cnt_q  <= bus.cmd_count;
                data_q <= bus.cmd_data;
                fill_q <= bus.cmd_fill;
                rot_q  <= bus.cmd_rot;
            end else if (state == ST_SHIFT && !bus.stall) begin
                cnt_q <= cnt_q - MAX_CNT_W'(1);
            end
        end
    end

    assign right_q  = (op_q != OP_SHL);
    assign shifting = (state == ST_SHIFT) && !bus.stall;

    assign bus.S          = ((state == ST_SHIFT) && bus.stall) ? S_HOLD : s_q;
    assign bus.I          = data_q;
    assign bus.MSB_in     = rot_q ? bus.A[0] : fill_q;
    assign bus.LSB_in     = rot_q ? bus.A[3] : fill_q;
    assign bus.serial_out = shifting ? (right_q ? bus.A[0] : bus.A[3]) : 1'b0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cmd_ready  = ready_q;

    a_shift_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
        (state == ST_SHIFT) |-> (cnt_q != '0));
    a_done_implies_busy: assert property (@(posedge clk) disable iff (rst)
        done_q |-> busy_q);
endmodule

// File: tb/tb_shift_register_controller.sv
// Scoreboard bench: spec-level model predicts each command's outcome; a negedge monitor checks on done.
module tb_shift_register_controller;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic reg_clr;
    logic [3:0] reg_A;

    always #5 clk = ~clk;

    shift_register_controller_if #(.MAX_CNT_W(CW)) bus();

    shift_register_controller #(.MAX_CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural 4-bit universal shift register sharing the clock.
    always @(posedge clk) begin
        if (reg_clr) reg_A <= 4'b0000;
        else begin
            case (bus.S)
                2'b01:   reg_A <= {bus.MSB_in, reg_A[3:1]};
                2'b10:   reg_A <= {reg_A[2:0], bus.LSB_in};
                2'b11:   reg_A <= bus.I;
                default: reg_A <= reg_A;
            endcase
        end
    end
    assign bus.A = reg_A;

    typedef struct {
        int          a;
        int          nbits;
        logic [15:0] bits;
        int          nload;
        int          dir;
    } exp_t;

    exp_t expq[$];
    int total = 0;
    int bad = 0;
    int ref_A;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic exp_t model(input int op, input int count, input int data,
                                   input int fill, input int rot, input int start);
        exp_t e;
        int v, n, b;
        bit right;
        e.nload = (op == 0 || op == 3) ? 1 : 0;
        v       = (e.nload == 1) ? data : start;
        n       = (op == 0) ? 0 : count;
        right   = (op != 2);
        e.bits  = '0;
        e.nbits = n;
        e.dir   = (n == 0) ? 0 : (right ? 2 : 1);
        for (int i = 0; i < n; i++) begin
            if (right) begin
                b = v % 2;
                v = v / 2 + (rot != 0 ? b : fill) * 8;
            end else begin
                b = v / 8;
                v = (v * 2) % 16 + (rot != 0 ? b : fill);
            end
            e.bits[i] = b[0];
        end
        e.a = v;
        return e;
    endfunction

    // Monitor
    int m_busy, m_load, m_stall, m_nbits, idle_bad;
    logic [15:0] m_bits;
    bit m_saw01, m_saw10, m_stall_ok, m_ready_ok, post_done;

    task automatic mon_clear();
        m_busy = 0; m_load = 0; m_stall = 0; m_nbits = 0; m_bits = '0;
        m_saw01 = 0; m_saw10 = 0; m_stall_ok = 1; m_ready_ok = 1;
    endtask

    initial begin
        mon_clear();
        idle_bad  = 0;
        post_done = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_clear();
            post_done = 0;
        end else begin
            if (post_done) begin
                check("ready_after_done", int'(bus.cmd_ready), 1);
                check("busy_after_done", int'(bus.busy), 0);
                post_done = 0;
            end
            if (bus.done) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("final_A", int'(bus.A), e.a);
                    check("shift_cycles", m_nbits, e.nbits);
                    check("serial_bits", int'(m_bits), int'(e.bits));
                    check("load_cycles", m_load, e.nload);
                    check("latency", m_busy, e.nload + e.nbits + m_stall);
                    check("direction", int'({m_saw01, m_saw10}), e.dir);
                    check("stall_gating", int'(m_stall_ok), 1);
                    check("ready_low_busy", int'(m_ready_ok), 1);
                    check("done_outputs", int'({bus.S, bus.serial_out, bus.cmd_ready}), 0);
                    check("done_busy", int'(bus.busy), 1);
                end
                post_done = 1;
                mon_clear();
            end else if (bus.busy) begin
                m_busy++;
                if (bus.cmd_ready) m_ready_ok = 0;
                case (bus.S)
                    2'b11: m_load++;
                    2'b01, 2'b10: begin
                        if (m_nbits < 16) m_bits[m_nbits] = bus.serial_out;
                        m_nbits++;
                        if (bus.S == 2'b01) m_saw01 = 1; else m_saw10 = 1;
                    end
                    default: begin
                        m_stall++;
                        if (!bus.stall || bus.serial_out) m_stall_ok = 0;
                    end
                endcase
            end else begin
                if (bus.S != 2'b00 || bus.serial_out || !bus.cmd_ready) idle_bad++;
            end
        end
    end

    task automatic issue(input int op, input int count, input int data, input int fill,
                         input int rot, input logic [15:0] spat, input bit rstall,
                         input bit nowait);
        exp_t e;
        int k;
        bit acc;
        bus.cmd_op    = op[1:0];
        bus.cmd_count = count[CW-1:0];
        bus.cmd_data  = data[3:0];
        bus.cmd_fill  = fill[0];
        bus.cmd_rot   = rot[0];
        bus.cmd_valid = 1'b1;
        acc = 0;
        k = 0;
        while (!acc && k < 64) begin
            acc = bus.cmd_ready;
            bus.stall = (!acc && rstall) ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            k++;
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
        end else begin
            e = model(op, count, data, fill, rot, ref_A);
            expq.push_back(e);
            ref_A = e.a;
            bus.cmd_valid = 1'b0;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_count = CW'($urandom);
            bus.cmd_data  = 4'($urandom);
            bus.cmd_fill  = 1'($urandom);
            bus.cmd_rot   = 1'($urandom);
            if (!nowait) begin
                k = 1;
                while (!bus.cmd_ready && k < 64) begin
                    bus.stall = rstall ? ($urandom_range(0, 3) == 0) : spat[k];
                    @(posedge clk); #1;
                    k++;
                end
                bus.stall = 1'b0;
                if (!bus.cmd_ready) check("done_timeout", 0, 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;
        int k;
        rst = 1'b1;
        reg_clr = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_count = '0;
        bus.cmd_data = 4'h0;
        bus.cmd_fill = 1'b0;
        bus.cmd_rot = 1'b0;
        bus.stall = 1'b0;
        ref_A = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reg_clr = 1'b0;
        check("reset_S", int'(bus.S), 0);
        check("reset_I", int'(bus.I), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_ready", int'(bus.cmd_ready), 1);
        check("reset_serial_out", int'(bus.serial_out), 0);

        issue(0, 0, 4'b1010, 0, 0, 16'h0, 0, 0);
        issue(1, 2, 0, 1, 0, 16'h0, 0, 0);
        issue(0, 0, 4'b1010, 0, 0, 16'h0, 0, 0);
        issue(2, 1, 0, 0, 1, 16'h0, 0, 0);
        issue(3, 4, 4'b0011, 0, 0, 16'h0008, 0, 0);
        issue(2, 0, 0, 1, 0, 16'h0, 0, 0);

        // Abandon an SHR 5 in its third shift cycle.
        bus.cmd_op = 2'b01; bus.cmd_count = CW'(5); bus.cmd_fill = 1'b1;
        bus.cmd_rot = 1'b0; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("rst_cmd_accepted", int'(bus.busy), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_S", int'(bus.S), 0);
        check("midrst_ready", int'(bus.cmd_ready), 1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_serial_out", int'(bus.serial_out), 0);
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) saw_done = 1;
            @(posedge clk); #1;
        end
        check("midrst_no_done", int'(saw_done), 0);
        ref_A = int'(reg_A);
        issue(0, 0, 4'b0110, 0, 0, 16'h0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            bit nw;
            nw = ($urandom_range(0, 1) == 1);
            issue($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 1), 16'h0, 1, nw);
            if (!nw) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        k = 0;
        while (!bus.cmd_ready && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_drained", expq.size(), 0);
        check("idle_outputs", idle_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_register_controller.md
# shift_register_controller

Sequencing controller for the team's 4-bit universal shift register, which has modes hold/shift-right/shift-left/parallel-load selected by S = 00/01/10/11. The controller accepts one command at a time over a valid/ready handshake. It drives the register's S, I, MSB_in and LSB_in, and counts shift cycles. It produces a per-cycle serial output bit and a done pulse, so upstream logic can use the register as a loader, serializer or rotator without hand-sequencing S.

## Interface
Parameters:
- MAX_CNT_W, 3: width of the shift-count field; commands request 0..(2^MAX_CNT_W − 1) shift cycles.

Ports:
- clk  in  1  rising-edge clock, shared with the shift register.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 LOAD, 01 SHR, 10 SHL, 11 LOAD_SHR (load then shift right).
- cmd_count  in  MAX_CNT_W  number of shift cycles; ignored for LOAD.
- cmd_data  in  4  parallel-load value.
- cmd_fill  in  1  serial fill bit for shifts when cmd_rot = 0.
- cmd_rot  in  1  1 = rotate: fill comes from the register's outgoing end bit.
- stall  in  1  freeze the shift sequence for this cycle.
- A  in  4  current register contents, fed back from the register.
- S  out  2  mode select to the register.
- I  out  4  parallel data to the register.
- MSB_in  out  1  serial input for shift right.
- LSB_in  out  1  serial input for shift left.
- serial_out  out  1  bit leaving the register this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1, S = 00.
  - On cmd_valid & cmd_ready, the controller latches op, count, data, fill and rot.
  - Next state is LOAD for LOAD and LOAD_SHR. For SHR and SHL it is SHIFT if count ≠ 0, otherwise DONE.
- LOAD:
  - S = 11, I = latched data. The register captures the data at the end of this cycle.
  - Next state is DONE for LOAD.
  - For LOAD_SHR, next state is SHIFT if count ≠ 0, otherwise DONE.
- SHIFT:
  - Direction is right for SHR and LOAD_SHR, left for SHL.
  - With stall = 0:
    - S = 01 (right) or 10 (left).
    - The remaining-count register decrements.
    - The state leaves to DONE on the cycle the remaining count is 1.
  - With stall = 1: S = 00 and the count is held.
- DONE: done = 1, S = 00. Next state is IDLE.
- Serial inputs:
  - MSB_in = rot ? A[0] : fill.
  - LSB_in = rot ? A[3] : fill.
  - Both are combinational from A and are only meaningful in SHIFT.
- serial_out:
  - Equals A[0] in SHIFT-right and A[3] in SHIFT-left.
  - Is 0 in all other states and during stall cycles.
- I:
  - Holds the latched data from acceptance until the next acceptance. It is 0 after reset.
  - The register ignores I unless S = 11.
- Command inputs are sampled only at acceptance. Changes while busy have no effect.
- cmd_valid held high during DONE is not accepted until the following IDLE cycle.

## Timing
- S, I, busy, done and cmd_ready are decoded from registered state only. There is no combinational path from cmd_* or stall to S.
  - Exception: the stall gating of S in SHIFT is combinational from stall.
- Cycle latency after the accept edge:
  - LOAD: LOAD (1) + DONE (1). done is high in the 2nd cycle and cmd_ready returns in the 3rd.
  - SHR/SHL count N: N + (stall cycles) shift cycles + DONE.
  - LOAD_SHR count N: 1 + N + (stall cycles) + DONE.
  - count 0 with SHR/SHL: DONE in the first cycle after accept, register unchanged.
- Back-to-back throughput: one command per (latency + 1) cycles, because IDLE must be visited.
- Reset (sync, rst = 1 at a rising edge):
  - state = IDLE, count = 0, I = 0000, S = 00.
  - done = 0, busy = 0, serial_out = 0, cmd_ready = 1 from the first post-reset cycle.
- Reset mid-operation abandons the command, with no done pulse.
  - The register retains its partial contents; it has its own reset.
- rst has priority over stall and cmd_valid in the same cycle.
- The controller relies on the register sampling at the same clk edge, with no extra pipelining.

## Test plan
- LOAD 1010 -> S = 11 for exactly one cycle; A = 1010 when done pulses; cmd_ready returns the cycle after.
- SHR, count 2, fill 1, rot 0, from A = 1010 -> A steps 1101, 1110; serial_out 0, 1; done 3 cycles after accept.
- SHL, count 1, rot 1, from A = 1010 -> LSB_in = 1, A = 0101, serial_out = 1.
- LOAD_SHR 0011, count 4, fill 0, with stall high for the 2nd shift cycle -> serial_out sequence 1, 1, 0, 0 over the four non-stalled shift cycles; S = 00 in the stalled cycle; final A = 0000; done 7 cycles after accept.
- SHL, count 0 -> no cycle with S ≠ 00; done the cycle after accept; A unchanged.
- SHR count 5 with rst asserted in the 3rd shift cycle -> next cycle is IDLE with S = 00 and cmd_ready = 1; no done pulse; a new LOAD 0110 then completes normally.
